// File: rtl/operate_button_encoder.sv
// -----------------------------------------------------------------------------
// operate_button_encoder
//
// Turns NUM_BTN raw push buttons into UART "operate" frames of the form
// {1'b1, one-hot op, 2'b10}.
//   - Each button bit passes through a 2-flop synchroniser.
//   - One shared counter debounces the whole vector. A vector is committed to
//     `stable` once it has been seen unchanged for DEBOUNCE_CNT+1 cycles.
//   - data_operate is a level: the frame for the current debounced button.
//     It shows the IGNORE frame when no button is pressed or when several
//     buttons are pressed together.
//   - A press event is a commit of a new one-hot vector. Each press event
//     produces one command on a valid/ready handshake. With REPEAT_EN, the
//     command is reissued every REPEAT_CNT+1 cycles while the button is held.
//
// Ports
//   uart_clk      sole clock
//   rst_n         asynchronous active-low reset
//   buttons       raw asynchronous button levels, bit i -> op bit i
//   data_operate  level frame of the current debounced operation
//   cmd_data      press-event frame, held stable while cmd_valid=1
//   cmd_valid     press-event command pending
//   cmd_ready     transmitter accepts cmd_data when cmd_valid & cmd_ready
//   overrun       one-cycle pulse: press committed while a command was pending
// -----------------------------------------------------------------------------
module operate_button_encoder #(
  parameter int NUM_BTN      = 5,
  parameter int DEBOUNCE_CNT = 15000,
  parameter int CNT_W        = 21,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_CNT   = 1000000,
  localparam int FRAME_W     = NUM_BTN + 3
) (
  input  logic               uart_clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] buttons,
  output logic [FRAME_W-1:0] data_operate,
  output logic [FRAME_W-1:0] cmd_data,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               overrun
);

  typedef logic [NUM_BTN-1:0] btn_t;
  typedef logic [FRAME_W-1:0] frame_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam cnt_t   DB_LAST      = CNT_W'(DEBOUNCE_CNT - 1);
  localparam cnt_t   DB_MAX       = CNT_W'(DEBOUNCE_CNT);
  localparam cnt_t   RPT_LAST     = CNT_W'(REPEAT_CNT - 1);
  localparam frame_t IGNORE_FRAME = {1'b1, {NUM_BTN{1'b0}}, 2'b10};

  function automatic logic is_onehot(input btn_t v);
    return (v != '0) && ((v & (v - NUM_BTN'(1))) == '0);
  endfunction

  function automatic frame_t make_frame(input btn_t op_v);
    return {1'b1, op_v, 2'b10};
  endfunction

  // ---------------------------------------------------------------------------
  // Synchroniser and debouncer
  // ---------------------------------------------------------------------------
  btn_t sync1_q, sync2_q;
  btn_t prev_q;
  btn_t stable_q, stable_d;
  cnt_t cnt_q;
  logic commit;
  logic press_evt;
  btn_t op;

  // Commit only while the input still agrees with prev. The counter
  // saturates at DEBOUNCE_CNT, so a given run commits exactly once.
  assign commit    = (sync2_q == prev_q) && (cnt_q == DB_LAST);
  assign stable_d  = commit ? prev_q : stable_q;
  // A press is a commit to a one-hot vector that differs from the current one.
  assign press_evt = commit && (prev_q != stable_q) && is_onehot(prev_q);
  assign op        = is_onehot(stable_q) ? stable_q : '0;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= buttons;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      if (sync2_q != prev_q) begin
        prev_q <= sync2_q;
        cnt_q  <= '0;
      end else if (cnt_q != DB_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output frame and command FSM
  // ---------------------------------------------------------------------------
  state_t state_q;
  frame_t data_operate_q;
  frame_t cmd_data_q;
  logic   cmd_valid_q;
  logic   overrun_q;
  btn_t   last_op_q;
  cnt_t   rpt_q;

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      data_operate_q <= IGNORE_FRAME;
      cmd_data_q     <= IGNORE_FRAME;
      cmd_valid_q    <= 1'b0;
      overrun_q      <= 1'b0;
      last_op_q      <= '0;
      rpt_q          <= '0;
    end else begin
      data_operate_q <= make_frame(op);
      overrun_q      <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (press_evt) begin
            cmd_data_q  <= make_frame(prev_q);
            last_op_q   <= prev_q;
            cmd_valid_q <= 1'b1;
            state_q     <= PEND;
          end
        end

        PEND: begin
          // The pending command is never replaced; a press that arrives now
          // is reported and dropped. A release does not cancel the command.
          if (press_evt) begin
            overrun_q <= 1'b1;
          end
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            rpt_q       <= '0;
            state_q     <= HOLD;
          end
        end

        HOLD: begin
          // Compare against the post-edge stable value. A press that commits
          // on this edge is then issued at once instead of being lost.
          if (stable_d != last_op_q) begin
            if (press_evt) begin
              cmd_data_q  <= make_frame(prev_q);
              last_op_q   <= prev_q;
              cmd_valid_q <= 1'b1;
              state_q     <= PEND;
            end else begin
              state_q <= IDLE;
            end
          end else if (REPEAT_EN != 0) begin
            if (rpt_q == RPT_LAST) begin
              cmd_valid_q <= 1'b1;
              state_q     <= PEND;
            end else begin
              rpt_q <= rpt_q + CNT_W'(1);
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_operate = data_operate_q;
  assign cmd_data     = cmd_data_q;
  assign cmd_valid    = cmd_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/operate_button_encoder.md
Name: operate_button_encoder

Overview:
Parametrised next-generation traveler operate encoder. Synchronises and debounces NUM_BTN push buttons, then decodes a single pressed button into a UART operate frame {1'b1, one-hot op, 2'b10}. Presents the current operate frame as a level. Also issues one press-event command per press over a valid/ready handshake to the UART transmitter, with optional hold-to-repeat.

Parameters:
NUM_BTN, 5, number of buttons; op field width; frame width FRAME_W = NUM_BTN+3
DEBOUNCE_CNT, 15000, stable cycles required before a button vector is committed (>=2)
CNT_W, 21, debounce/repeat counter width; must hold max(DEBOUNCE_CNT, REPEAT_CNT)
REPEAT_EN, 0, 1 = reissue the command while the button stays held
REPEAT_CNT, 1000000, cycles between repeated commands while held (REPEAT_EN=1 only)

Ports:
uart_clk  in  1  sole clock
rst_n  in  1  asynchronous active-low reset
buttons  in  NUM_BTN  raw asynchronous button levels; bit i maps to op bit i
data_operate  out  FRAME_W  level frame of the current debounced operation
cmd_data  out  FRAME_W  press-event frame; stable while cmd_valid=1
cmd_valid  out  1  press-event command pending
cmd_ready  in  1  UART transmitter accepts cmd_data when cmd_valid & cmd_ready
overrun  out  1  one-cycle pulse: a new valid press was committed while a command was still pending

Behaviour:
- Reset (async, rst_n=0): sync flops, prev, stable and all counters go to 0. data_operate = IGNORE frame {1,0..0,2'b10}. cmd_data = IGNORE. cmd_valid=0, overrun=0. FSM goes to IDLE. Asserting reset mid-handshake drops the pending command.
- Sync: 2-flop synchroniser per bit gives sync_btn. Input-to-debouncer latency is 2 cycles.
- Debounce: uses one shared counter for the whole vector.
  - If sync_btn != prev: prev <= sync_btn, cnt <= 0.
  - Otherwise cnt increments and saturates at DEBOUNCE_CNT. It never wraps.
  - On the cycle cnt == DEBOUNCE_CNT-1, stable <= prev.
  - A level held continuously therefore commits DEBOUNCE_CNT+1 cycles after it first appears in sync_btn.
  - Any glitch shorter than that never reaches stable.
- Decode: op = stable when stable is exactly one-hot. Otherwise op = 0 (none or multiple pressed gives IGNORE).
- data_operate is registered from decode and updates 1 cycle after stable changes.
- Press event: the cycle on which stable changes to a one-hot value different from the previous stable value.
- FSM:
  - IDLE:
    - On a press event: cmd_data <= frame(op), cmd_valid <= 1, go to PEND.
  - PEND:
    - cmd_data and cmd_valid are held constant until cmd_valid & cmd_ready.
    - On handshake: cmd_valid <= 0, rpt_cnt <= 0, go to HOLD.
    - A new press event while in PEND: the command is not replaced, and overrun pulses for 1 cycle.
    - Release while in PEND does not cancel the command.
  - HOLD:
    - If stable != the op of the last command: go to IDLE. A press event on that same cycle is treated as in IDLE (immediate PEND).
    - Else if REPEAT_EN and rpt_cnt == REPEAT_CNT-1: cmd_valid <= 1 with the same cmd_data, go to PEND.
    - Else rpt_cnt increments.
- cmd_ready=1 permanently: each command is visible for exactly 1 cycle.
- cmd_ready asserted while cmd_valid=0 has no effect.
- Only one command is outstanding at a time; there is no queue.

Test Plan:
1. DEBOUNCE_CNT=4, reset then idle -> data_operate=8'b1_00000_10, cmd_valid=0, overrun=0.
2. buttons=5'b00001 held, cmd_ready=1 -> data_operate=8'b1_00001_10 within 2+5+1 cycles of the input change; cmd_valid high exactly 1 cycle with cmd_data=8'b1_00001_10; no further commands while held (REPEAT_EN=0).
3. Bit 2 pulsed for 3 cycles, then bit 2 bouncing with toggles every 2 cycles for 20 cycles -> no change on data_operate, no cmd_valid.
4. buttons=5'b10010 held -> data_operate stays IGNORE and no command; then release bit 4 -> cmd_data=8'b1_00010_10.
5. cmd_ready=0, press bit 0, release, press bit 3 -> cmd_valid stays 1 with cmd_data=8'b1_00001_10; overrun pulses once at the bit-3 commit; after cmd_ready=1 for one cycle, cmd_valid=0.
6. REPEAT_EN=1, REPEAT_CNT=10, cmd_ready=1, bit 1 held 40 cycles after commit -> command pulses spaced 11 cycles apart (HOLD 10 + PEND 1). Assert rst_n=0 mid-PEND -> cmd_valid=0 asynchronously and data_operate=IGNORE.
